cache_sa: RTL and testbench
===========================

// Module: cache_sa
// PURPOSE
//  Parametrised N-way set-associative, write-through, no-write-allocate L1 cache between one CPU
//  Avalon-MM slave port (s0) and one burst-capable Avalon-MM master port (m0). Next generation of
//  the fixed 8 KB cache: ways, line length and size are parameters. Adds uncached bypass and flush.
// PARAMETERS
//  SIZE        8192  total data capacity in bytes (power of two)
//  WAYS        2     associativity, power of two, 1..8
//  LINE_WORDS  4     32-bit words per line, power of two, 2..16; also the refill burst length
//  BURST_W     8     m0_burstCount width (CACHE_AVALON_BURST_COUNT_WIDTH)
// PORTS
//  clk                 in   1        clock
//  rest                in   1        reset, asynchronous, active-low
//  s0_address          in   32       CPU byte address; bits [1:0] ignored
//  s0_byteEnable       in   4        write byte lanes
//  s0_read/s0_write    in   1        CPU request strobes, never both high
//  s0_writeData        in   32       CPU write data
//  s0_waitRequest      out  1        request not accepted this cycle
//  s0_readData         out  32       read data, valid while s0_readDataValid is high
//  s0_readDataValid    out  1        one-cycle pulse per accepted read
//  m0_address..m0_writeData, m0_waitRequest, m0_readData, m0_readDataValid: Avalon-MM master
//  m0_beginBurstTransfer out 1       high on the first cycle of each m0 transfer
//  m0_burstCount       out  BURST_W  LINE_WORDS for a refill, 1 otherwise
//  cfg_enable          in   1        0 = every access bypasses the cache (uncached)
//  ctr_flush           in   1        one-cycle pulse: invalidate every line
//  ctr_busy            out  1        high while a flush is pending or executing
// BEHAVIOUR
//  Widths: OFF_W=log2(LINE_WORDS), SETS=SIZE/(4*LINE_WORDS*WAYS), IDX_W=log2(SETS),
//   TAG_W=30-IDX_W-OFF_W. Address split: tag | index | word offset | 2'b00.
//  Reset values: FSM=IDLE, all valid bits 0, victim pointer 0, every s0/m0 output 0, ctr_busy 0.
//  Valid bits live in flops so that reset clears them; tags and data live in synchronous RAM.
//  FSM: IDLE, LOOKUP, REFILL, RESPOND, WR_THRU, BYP_RD, FLUSH.
//   IDLE: s0_waitRequest=0. Pending flush wins over s0 -> FLUSH. A read or write with cfg_enable=0
//    is accepted and goes to BYP_RD or WR_THRU. A read or write with cfg_enable=1 is latched -> LOOKUP.
//   LOOKUP: tag compare on all ways. Read hit -> s0_readDataValid one cycle later. A read hit
//    accepted at edge T therefore returns at T+2, with the FSM back in IDLE at T+2.
//    Read miss -> REFILL. Write with or without a hit -> WR_THRU; a write hit updates data RAM
//    through the byte enables in this cycle.
//   REFILL: m0_read=1, m0_beginBurstTransfer=1 (first cycle only), m0_burstCount=LINE_WORDS.
//    Address is aligned to the line. All signals are held until m0_waitRequest=0. Each
//    m0_readDataValid beat is written to the victim way at offset beat#. After the last beat:
//    tag written, valid set, victim pointer += 1 modulo WAYS (one global round-robin) -> RESPOND.
//   RESPOND: s0_readData = the requested word of the filled line, s0_readDataValid=1 -> IDLE.
//   WR_THRU: single-beat m0_write using the latched address, data and byteEnable. Held until
//    m0_waitRequest=0, then -> IDLE. No allocate on a write miss.
//   BYP_RD: single-beat m0_read, burstCount=1. The m0 data is forwarded unchanged to s0 with
//    readDataValid and is never cached; -> IDLE on that beat.
//   FLUSH: clears every valid bit in one cycle -> IDLE; ctr_busy drops in the same cycle.
//  s0_waitRequest=1 in every state except IDLE. Only one CPU request is outstanding at a time.
//  A ctr_flush arriving outside IDLE is latched (ctr_busy=1) and runs on the next IDLE. It does not
//   abort a refill in progress. A second flush pulse while one is pending is merged.
//  m0_readDataValid outside REFILL or BYP_RD is ignored.
//  A cfg_enable change is sampled only in IDLE; lines already valid stay valid.
//  Asserting rest mid-refill: FSM to IDLE, m0 strobes drop, the partial line is never marked valid.
//  The victim pointer ignores valid bits. Refills into a set that is not full still follow the pointer.
// STRUCTURE
//  cache_sa_pkg: state enum cache_sa_state_t, width helpers (off_w, idx_w, tag_w), burst constants.
//  cache_sa_way_ram: per-way synchronous RAM, 1 read + 1 byte-enabled write port, holds data and tag.
//   Instantiated WAYS times with a generate loop. cache_sa holds the FSM, valid flops and victim pointer.
// TESTING
//  1 Cold read 0x0000_1004, memory returns 0xA0..A3 -> one 4-beat burst at 0x1000, s0 gets 0xA1, valid set.
//  2 Read 0x1008 right after -> no m0 activity, s0_readDataValid exactly 2 cycles after acceptance, data 0xA2.
//  3 Write 0x1004=0xDEADBEEF with byteEnable=4'b0011 -> m0 single write with be 0011; reread gives 0xA1 with
//    the low half replaced by 0xBEEF; write to an unmapped line causes no refill.
//  4 WAYS=2: fill 0x1000, 0x3000, 0x5000 (same set) -> the third refill evicts way0; 0x1000 misses again.
//  5 cfg_enable=0 read 0x1004 -> single m0 read with burstCount=1, line state untouched.
//    ctr_flush during a refill -> ctr_busy=1, flush runs after the refill, next read misses.
//  6 rest asserted on the 2nd refill beat -> all outputs 0, the next read of that line refills again.

Source files
------------

// File: rtl/cache_sa_pkg.sv
// Shared types and address-width helpers for the set-associative L1 cache.
package cache_sa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_REFILL  = 3'd2,
    ST_RESPOND = 3'd3,
    ST_WR_THRU = 3'd4,
    ST_BYP_RD  = 3'd5,
    ST_FLUSH   = 3'd6
  } cache_sa_state_t;

  localparam int unsigned WORD_BYTES  = 4;
  localparam int unsigned SINGLE_BEAT = 1;   // burst count of every non-refill transfer

  function automatic int unsigned off_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned size, input int unsigned ways,
                                        input int unsigned line_words);
    return $clog2(size / (WORD_BYTES * line_words * ways));
  endfunction

  function automatic int unsigned tag_w(input int unsigned size, input int unsigned ways,
                                        input int unsigned line_words);
    return 30 - idx_w(size, ways, line_words) - off_w(line_words);
  endfunction

endpackage

// File: rtl/cache_sa_way_ram.sv
// One cache way: synchronous data RAM (byte-enabled write) and tag RAM, one read port each.
module cache_sa_way_ram #(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned OFF_W = 2,
  parameter int unsigned TAG_W = 20
) (
  input  logic                   clk,
  input  logic [IDX_W+OFF_W-1:0] rd_addr,
  output logic [31:0]            rd_data,
  output logic [TAG_W-1:0]       rd_tag,
  input  logic                   wr_en,
  input  logic [IDX_W+OFF_W-1:0] wr_addr,
  input  logic [3:0]             wr_be,
  input  logic [31:0]            wr_data,
  input  logic                   tag_we,
  input  logic [IDX_W-1:0]       tag_idx,
  input  logic [TAG_W-1:0]       tag_data
);

  logic [3:0][7:0]   data_mem [2**(IDX_W+OFF_W)];
  logic [TAG_W-1:0]  tag_mem  [2**IDX_W];

  // Registered reads; writes land per byte lane, tag written once per refill.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (wr_en && wr_be[b]) data_mem[wr_addr][b] <= wr_data[8*b +: 8];
    if (tag_we) tag_mem[tag_idx] <= tag_data;
    rd_data <= data_mem[rd_addr];
    rd_tag  <= tag_mem[rd_addr[IDX_W+OFF_W-1:OFF_W]];
  end

endmodule

// File: rtl/cache_sa.sv
// N-way set-associative write-through, no-write-allocate L1 cache with uncached bypass and flush.
module cache_sa
  import cache_sa_pkg::*;
#(
  parameter int unsigned SIZE       = 8192,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned BURST_W    = 8
) (
  input  logic               clk,
  input  logic               rest,
  input  logic [31:0]        s0_address,
  input  logic [3:0]         s0_byteEnable,
  input  logic               s0_read,
  input  logic               s0_write,
  input  logic [31:0]        s0_writeData,
  output logic               s0_waitRequest,
  output logic [31:0]        s0_readData,
  output logic               s0_readDataValid,
  output logic [31:0]        m0_address,
  output logic [3:0]         m0_byteEnable,
  output logic               m0_read,
  output logic               m0_write,
  output logic [31:0]        m0_writeData,
  input  logic               m0_waitRequest,
  input  logic [31:0]        m0_readData,
  input  logic               m0_readDataValid,
  output logic               m0_beginBurstTransfer,
  output logic [BURST_W-1:0] m0_burstCount,
  input  logic               cfg_enable,
  input  logic               ctr_flush,
  output logic               ctr_busy
);

  localparam int unsigned OFF_W = off_w(LINE_WORDS);
  localparam int unsigned IDX_W = idx_w(SIZE, WAYS, LINE_WORDS);
  localparam int unsigned TAG_W = tag_w(SIZE, WAYS, LINE_WORDS);
  localparam int unsigned SETS  = 1 << IDX_W;
  localparam int unsigned VIC_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned RA_W  = IDX_W + OFF_W;

  cache_sa_state_t           state_q, state_d;
  logic [31:2]               addr_q, addr_d;
  logic [3:0]                be_q, be_d;
  logic [31:0]               wdata_q, wdata_d, rdata_q, rdata_d;
  logic                      is_wr_q, is_wr_d, cmd_done_q, cmd_done_d;
  logic                      begin_q, begin_d, flush_pend_q, flush_pend_d;
  logic [WAYS-1:0][SETS-1:0] valid_q, valid_d;
  logic [VIC_W-1:0]          victim_q, victim_d;
  logic [OFF_W-1:0]          beat_q, beat_d;

  logic [RA_W-1:0]           ram_raddr, ram_waddr;
  logic [WAYS-1:0]           ram_we, tag_we, hit_vec;
  logic [3:0]                ram_be;
  logic [31:0]               ram_wdata, hit_data;
  logic [WAYS-1:0][31:0]     way_data;
  logic [WAYS-1:0][TAG_W-1:0] way_tag;
  logic [TAG_W-1:0]          tag_f;
  logic [IDX_W-1:0]          idx_f;
  logic [OFF_W-1:0]          off_f;
  logic                      unused_addr;

  assign tag_f       = addr_q[31 -: TAG_W];
  assign idx_f       = addr_q[OFF_W+2 +: IDX_W];
  assign off_f       = addr_q[2 +: OFF_W];
  assign unused_addr = ^s0_address[1:0];
  // The RAM read is launched on the accepting edge so tags are ready in LOOKUP.
  assign ram_raddr   = (state_q == ST_IDLE) ? s0_address[RA_W+1:2] : addr_q[RA_W+1:2];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_sa_way_ram #(.IDX_W(IDX_W), .OFF_W(OFF_W), .TAG_W(TAG_W)) u_ram (
      .clk     (clk),
      .rd_addr (ram_raddr),
      .rd_data (way_data[w]),
      .rd_tag  (way_tag[w]),
      .wr_en   (ram_we[w]),
      .wr_addr (ram_waddr),
      .wr_be   (ram_be),
      .wr_data (ram_wdata),
      .tag_we  (tag_we[w]),
      .tag_idx (idx_f),
      .tag_data(tag_f)
    );
  end

  // Tag compare across all ways; at most one way can hit.
  always_comb begin
    hit_vec  = '0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[w][idx_f] && (way_tag[w] == tag_f);
      if (hit_vec[w]) hit_data = hit_data | way_data[w];
    end
  end

  // Next-state logic: FSM, request latch, refill beat tracking, valid bits, victim pointer.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    is_wr_d      = is_wr_q;
    cmd_done_d   = cmd_done_q;
    begin_d      = 1'b0;
    flush_pend_d = flush_pend_q | ctr_flush;
    valid_d      = valid_q;
    victim_d     = victim_q;
    beat_d       = beat_q;
    ram_we       = '0;
    tag_we       = '0;
    ram_waddr    = {idx_f, beat_q};
    ram_be       = 4'hF;
    ram_wdata    = m0_readData;
    case (state_q)
      ST_IDLE: begin
        if (flush_pend_q) begin
          state_d = ST_FLUSH;
        end else if (s0_read || s0_write) begin
          addr_d     = s0_address[31:2];
          be_d       = s0_byteEnable;
          wdata_d    = s0_writeData;
          is_wr_d    = s0_write;
          cmd_done_d = 1'b0;
          if (!cfg_enable) begin
            state_d = s0_write ? ST_WR_THRU : ST_BYP_RD;
            begin_d = 1'b1;
          end else begin
            state_d = ST_LOOKUP;
          end
        end
      end
      ST_LOOKUP: begin
        if (is_wr_q) begin
          ram_we    = hit_vec;
          ram_waddr = {idx_f, off_f};
          ram_be    = be_q;
          ram_wdata = wdata_q;
          state_d   = ST_WR_THRU;
          begin_d   = 1'b1;
        end else if (|hit_vec) begin
          rdata_d = hit_data;
          state_d = ST_RESPOND;
        end else begin
          state_d = ST_REFILL;
          begin_d = 1'b1;
          beat_d  = '0;
        end
      end
      ST_REFILL: begin
        if (m0_read && !m0_waitRequest) cmd_done_d = 1'b1;
        if (m0_readDataValid) begin
          ram_we[victim_q] = 1'b1;
          if (beat_q == off_f) rdata_d = m0_readData;
          beat_d = beat_q + 1'b1;
          if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
            tag_we[victim_q]          = 1'b1;
            valid_d[victim_q][idx_f]  = 1'b1;
            victim_d = (victim_q == VIC_W'(WAYS - 1)) ? '0 : victim_q + 1'b1;
            state_d  = ST_RESPOND;
          end
        end
      end
      ST_RESPOND: state_d = ST_IDLE;
      ST_WR_THRU: if (!m0_waitRequest) state_d = ST_IDLE;
      ST_BYP_RD: begin
        if (m0_read && !m0_waitRequest) cmd_done_d = 1'b1;
        if (m0_readDataValid) state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        valid_d      = '0;
        flush_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; valid bits are flops so reset invalidates the whole cache.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      is_wr_q      <= 1'b0;
      cmd_done_q   <= 1'b0;
      begin_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      victim_q     <= '0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      is_wr_q      <= is_wr_d;
      cmd_done_q   <= cmd_done_d;
      begin_q      <= begin_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      victim_q     <= victim_d;
      beat_q       <= beat_d;
    end
  end

  // Port outputs decoded from state; all zero in IDLE with nothing pending.
  always_comb begin
    s0_waitRequest        = !(state_q == ST_IDLE && !flush_pend_q);
    s0_readDataValid      = 1'b0;
    s0_readData           = '0;
    m0_address            = '0;
    m0_byteEnable         = '0;
    m0_read               = 1'b0;
    m0_write              = 1'b0;
    m0_writeData          = '0;
    m0_burstCount         = '0;
    m0_beginBurstTransfer = begin_q;
    ctr_busy              = flush_pend_q;
    case (state_q)
      ST_REFILL: begin
        m0_read       = !cmd_done_q;
        m0_address    = {addr_q[31:OFF_W+2], {(OFF_W+2){1'b0}}};
        m0_byteEnable = 4'hF;
        m0_burstCount = BURST_W'(LINE_WORDS);
      end
      ST_RESPOND: begin
        s0_readDataValid = 1'b1;
        s0_readData      = rdata_q;
      end
      ST_WR_THRU: begin
        m0_write      = 1'b1;
        m0_address    = {addr_q, 2'b00};
        m0_byteEnable = be_q;
        m0_writeData  = wdata_q;
        m0_burstCount = BURST_W'(SINGLE_BEAT);
      end
      ST_BYP_RD: begin
        m0_read          = !cmd_done_q;
        m0_address       = {addr_q, 2'b00};
        m0_byteEnable    = 4'hF;
        m0_burstCount    = BURST_W'(SINGLE_BEAT);
        s0_readDataValid = m0_readDataValid;
        s0_readData      = m0_readDataValid ? m0_readData : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_sa.sv
// Directed bench for cache_sa: memory slave model on m0, CPU read/write tasks on s0.
module tb_cache_sa;

  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        rest = 1'b0;
  logic [31:0] s0_address = '0, s0_writeData = '0;
  logic [3:0]  s0_byteEnable = '0;
  logic        s0_read = 1'b0, s0_write = 1'b0;
  logic        s0_waitRequest, s0_readDataValid;
  logic [31:0] s0_readData;
  logic [31:0] m0_address, m0_writeData, m0_readData;
  logic [3:0]  m0_byteEnable;
  logic        m0_read, m0_write, m0_waitRequest, m0_readDataValid, m0_beginBurstTransfer;
  logic [7:0]  m0_burstCount;
  logic        cfg_enable = 1'b1, ctr_flush = 1'b0, ctr_busy;
  logic        mwait = 1'b0;

  always #5 clk = ~clk;
  assign m0_waitRequest = mwait;

  cache_sa #(.SIZE(8192), .WAYS(2), .LINE_WORDS(LW), .BURST_W(8)) dut (
    .clk(clk), .rest(rest),
    .s0_address(s0_address), .s0_byteEnable(s0_byteEnable), .s0_read(s0_read),
    .s0_write(s0_write), .s0_writeData(s0_writeData), .s0_waitRequest(s0_waitRequest),
    .s0_readData(s0_readData), .s0_readDataValid(s0_readDataValid),
    .m0_address(m0_address), .m0_byteEnable(m0_byteEnable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writeData(m0_writeData), .m0_waitRequest(m0_waitRequest),
    .m0_readData(m0_readData), .m0_readDataValid(m0_readDataValid),
    .m0_beginBurstTransfer(m0_beginBurstTransfer), .m0_burstCount(m0_burstCount),
    .cfg_enable(cfg_enable), .ctr_flush(ctr_flush), .ctr_busy(ctr_busy)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  // Backing memory: line 0x1000 holds 0xA0..0xA3, everything else defaults to ~address.
  logic [31:0] mem [int unsigned];
  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    if (a[31:4] == 28'h100) return 32'hA0 + {30'd0, a[3:2]};
    return ~a;
  endfunction

  // m0 slave: beats driven on the negedge, commands observed after the bench settles inputs.
  logic [31:0] beat_fifo [$];
  int          rd_bursts = 0, byp_rds = 0, wr_cnt = 0, beats_given = 0, begin_cnt = 0;
  logic [31:0] last_rd_addr = '0, last_rd_cnt = '0, last_wr_addr = '0, last_wr_data = '0;
  logic [3:0]  last_wr_be = '0;

  initial begin
    logic [31:0] o;
    m0_readDataValid = 1'b0;
    m0_readData      = '0;
    forever begin
      @(negedge clk);
      if (!rest) begin
        beat_fifo.delete();
        m0_readDataValid = 1'b0;
        m0_readData      = '0;
      end else if (beat_fifo.size() > 0) begin
        m0_readData      = beat_fifo.pop_front();
        m0_readDataValid = 1'b1;
        beats_given++;
      end else begin
        m0_readDataValid = 1'b0;
        m0_readData      = '0;
      end
      #2;
      if (m0_beginBurstTransfer) begin_cnt++;
      if (rest && m0_read && !m0_waitRequest) begin
        last_rd_addr = m0_address;
        last_rd_cnt  = {24'd0, m0_burstCount};
        if (int'(m0_burstCount) == LW) rd_bursts++; else byp_rds++;
        for (int i = 0; i < int'(m0_burstCount); i++)
          beat_fifo.push_back(memrd(m0_address + 32'(4 * i)));
      end
      if (rest && m0_write && !m0_waitRequest) begin
        wr_cnt++;
        last_wr_addr = m0_address;
        last_wr_data = m0_writeData;
        last_wr_be   = m0_byteEnable;
        o = memrd(m0_address);
        for (int b = 0; b < 4; b++)
          if (m0_byteEnable[b]) o[8*b +: 8] = m0_writeData[8*b +: 8];
        mem[m0_address] = o;
      end
    end
  end

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d, output int lat);
    int g;
    step();
    s0_address = a;
    s0_read    = 1'b1;
    g = 0;
    while (s0_waitRequest && g < 100) begin step(); g++; end
    step();
    s0_read = 1'b0;
    lat = 1;
    while (!s0_readDataValid && lat < 200) begin step(); lat++; end
    chk("rd_valid_seen", {31'd0, s0_readDataValid}, 32'd1);
    d = s0_readData;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    int g;
    step();
    s0_address    = a;
    s0_writeData  = wd;
    s0_byteEnable = be;
    s0_write      = 1'b1;
    g = 0;
    while (s0_waitRequest && g < 100) begin step(); g++; end
    step();
    s0_write = 1'b0;
    g = 0;
    while (s0_waitRequest && g < 100) begin step(); g++; end
    chk("wr_done", {31'd0, s0_waitRequest}, 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    int lat, r0, b0, g;

    // Reset state
    step(); step();
    chk("rst_s0_wait",  {31'd0, s0_waitRequest}, 32'd0);
    chk("rst_s0_valid", {31'd0, s0_readDataValid}, 32'd0);
    chk("rst_m0_read",  {31'd0, m0_read}, 32'd0);
    chk("rst_m0_write", {31'd0, m0_write}, 32'd0);
    chk("rst_busy",     {31'd0, ctr_busy}, 32'd0);
    chk("rst_burstcnt", {24'd0, m0_burstCount}, 32'd0);
    rest = 1'b1;
    step();

    // 1: cold read -> one 4-beat line burst
    cpu_read(32'h1004, d, lat);
    chk("t1_data",   d, 32'hA1);
    chk("t1_bursts", rd_bursts, 1);
    chk("t1_addr",   last_rd_addr, 32'h1000);
    chk("t1_cnt",    last_rd_cnt, 32'd4);
    chk("t1_begin",  begin_cnt, 1);

    // 2: hit, exactly two cycles, no m0 traffic
    cpu_read(32'h1008, d, lat);
    chk("t2_data",   d, 32'hA2);
    chk("t2_lat",    lat, 2);
    chk("t2_bursts", rd_bursts, 1);

    // 3: write hit with partial byte enables, then write miss with no allocate
    cpu_write(32'h1004, 32'hDEADBEEF, 4'b0011);
    chk("t3_wr_cnt",  wr_cnt, 1);
    chk("t3_wr_addr", last_wr_addr, 32'h1004);
    chk("t3_wr_be",   {28'd0, last_wr_be}, 32'h3);
    chk("t3_wr_data", last_wr_data, 32'hDEADBEEF);
    cpu_read(32'h1004, d, lat);
    chk("t3_reread",  d, 32'h0000BEEF);
    chk("t3_lat",     lat, 2);
    cpu_write(32'h7010, 32'h12345678, 4'hF);
    chk("t3_miss_wr",  wr_cnt, 2);
    chk("t3_no_alloc", rd_bursts, 1);

    // 4: three lines into one set of a 2-way cache
    cpu_read(32'h3004, d, lat);
    chk("t4_3000", d, 32'hFFFFCFFB);
    cpu_read(32'h5004, d, lat);
    chk("t4_5000", d, 32'hFFFFAFFB);
    chk("t4_bursts", rd_bursts, 3);
    cpu_read(32'h3004, d, lat);
    chk("t4_3000_hit", lat, 2);
    chk("t4_3000_nob", rd_bursts, 3);
    cpu_read(32'h1004, d, lat);
    chk("t4_1000_miss", rd_bursts, 4);
    chk("t4_1000_data", d, 32'h0000BEEF);
    cpu_read(32'h7010, d, lat);
    chk("t4_7010_miss", rd_bursts, 5);
    chk("t4_7010_data", d, 32'h12345678);

    // 5a: uncached read
    cfg_enable = 1'b0;
    cpu_read(32'h1004, d, lat);
    chk("t5_byp_data", d, 32'h0000BEEF);
    chk("t5_byp_cnt",  last_rd_cnt, 32'd1);
    chk("t5_byp_addr", last_rd_addr, 32'h1004);
    chk("t5_byp_n",    byp_rds, 1);
    chk("t5_byp_nob",  rd_bursts, 5);
    cfg_enable = 1'b1;
    cpu_read(32'h1004, d, lat);
    chk("t5_still_hit", lat, 2);

    // Refill with a stalled command: held signals, single begin pulse
    mwait = 1'b1;
    b0 = begin_cnt;
    fork
      cpu_read(32'h6008, d, lat);
      begin
        step(); step(); step();
        chk("st_begin1", {31'd0, m0_beginBurstTransfer}, 32'd1);
        chk("st_read1",  {31'd0, m0_read}, 32'd1);
        step();
        chk("st_begin2", {31'd0, m0_beginBurstTransfer}, 32'd0);
        chk("st_read2",  {31'd0, m0_read}, 32'd1);
        chk("st_addr",   m0_address, 32'h6000);
        chk("st_cnt",    {24'd0, m0_burstCount}, 32'd4);
        mwait = 1'b0;
      end
    join
    chk("st_data",  d, 32'hFFFF9FF7);
    chk("st_begin", begin_cnt, b0 + 1);

    // 5b: flush during a refill is deferred, then invalidates everything
    fork
      cpu_read(32'h2000, d, lat);
      begin
        step(); step(); step(); step();
        ctr_flush = 1'b1;
        step();
        ctr_flush = 1'b0;
        chk("fl_busy",    {31'd0, ctr_busy}, 32'd1);
        chk("fl_nowait",  {31'd0, s0_waitRequest}, 32'd1);
      end
    join
    chk("fl_refill_data", d, 32'hFFFFDFFF);
    step(); step(); step();
    chk("fl_busy_drop", {31'd0, ctr_busy}, 32'd0);
    r0 = rd_bursts;
    cpu_read(32'h2000, d, lat);
    chk("fl_miss", rd_bursts, r0 + 1);
    cpu_read(32'h1004, d, lat);
    chk("fl_miss2", rd_bursts, r0 + 2);

    // 6: reset on the second refill beat
    step();
    s0_address = 32'h4000;
    s0_read    = 1'b1;
    step();
    s0_read = 1'b0;
    b0 = beats_given;
    g  = 0;
    while (beats_given < b0 + 2 && g < 50) begin step(); g++; end
    chk("r6_beats", beats_given, b0 + 2);
    rest = 1'b0;
    #1;
    chk("r6_s0_wait",  {31'd0, s0_waitRequest}, 32'd0);
    chk("r6_s0_valid", {31'd0, s0_readDataValid}, 32'd0);
    chk("r6_m0_read",  {31'd0, m0_read}, 32'd0);
    chk("r6_begin",    {31'd0, m0_beginBurstTransfer}, 32'd0);
    chk("r6_m0_addr",  m0_address, 32'h0);
    chk("r6_busy",     {31'd0, ctr_busy}, 32'd0);
    step(); step();
    rest = 1'b1;
    step();
    r0 = rd_bursts;
    cpu_read(32'h4000, d, lat);
    chk("r6_refill", rd_bursts, r0 + 1);
    chk("r6_data",   d, 32'hFFFFBFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
